// File: rtl/m_frame_pkg.sv
// ---------------------------------------------------------------------------
// m_frame_pkg
// Shared definitions for the user-data frame packer: sync word, header field
// offsets, FSM state encoding, the packed FSM control record and a helper
// that assembles the 128-bit header beat.
// ---------------------------------------------------------------------------
package m_frame_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hEB90146F;

    localparam int BEAT_W = 128;
    localparam int WORD_W = 512;

    // Header beat layout (bit offsets of each field's LSB).
    localparam int HDR_SYNC_LSB = 96;
    localparam int HDR_FCNT_LSB = 64;
    localparam int HDR_LEN_LSB  = 48;
    localparam int HDR_DROP_LSB = 32;
    localparam int HDR_OVF_BIT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } frameState_t;

    // Complete FSM state: the enum plus the beat/word position inside a frame.
    typedef struct packed {
        frameState_t state;
        logic [1:0]  beatIdx;
        logic [15:0] wordIdx;
    } frameCtl_t;

    function automatic logic [BEAT_W-1:0] buildHeader(
        input logic [31:0] frameCnt,
        input logic [15:0] frameLen,
        input logic [15:0] dropCnt,
        input logic        ovf
    );
        logic [BEAT_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_SYNC_LSB +: 32] = SYNC_WORD;
        hdr[HDR_FCNT_LSB +: 32] = frameCnt;
        hdr[HDR_LEN_LSB  +: 16] = frameLen;
        hdr[HDR_DROP_LSB +: 16] = dropCnt;
        hdr[HDR_OVF_BIT]        = ovf;
        return hdr;
    endfunction

endpackage

// File: rtl/m_usr_sync_fifo.sv
// ---------------------------------------------------------------------------
// m_usr_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// CpSv_Head_o whenever CpSl_Empty_o is low. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
// The caller guarantees it never pushes when full (unless popping in the same
// cycle) and never pops when empty.
//
// Ports:
//   CpSl_Clk_i    in   clock
//   CpSl_Rst_iN   in   asynchronous active-low reset (empties the FIFO)
//   CpSl_Push_i   in   write CpSv_Din_i this cycle
//   CpSv_Din_i    in   WIDTH-bit write data
//   CpSl_Pop_i    in   discard the head entry this cycle
//   CpSv_Head_o   out  head entry (valid when not empty)
//   CpSl_Full_o   out  all DEPTH entries occupied
//   CpSl_Empty_o  out  no entries
// ---------------------------------------------------------------------------
module m_usr_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8
) (
    input  logic             CpSl_Clk_i,
    input  logic             CpSl_Rst_iN,
    input  logic             CpSl_Push_i,
    input  logic [WIDTH-1:0] CpSv_Din_i,
    input  logic             CpSl_Pop_i,
    output logic [WIDTH-1:0] CpSv_Head_o,
    output logic             CpSl_Full_o,
    output logic             CpSl_Empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
        if (!CpSl_Rst_iN) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (CpSl_Push_i) wrPtr <= wrPtr + 1'b1;
            if (CpSl_Pop_i)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset: a flush is just the pointers returning to zero.
    always_ff @(posedge CpSl_Clk_i) begin
        if (CpSl_Push_i) mem[wrPtr[AW-1:0]] <= CpSv_Din_i;
    end

    assign CpSv_Head_o  = mem[rdPtr[AW-1:0]];
    assign CpSl_Empty_o = (wrPtr == rdPtr);
    assign CpSl_Full_o  = (wrPtr[AW] != rdPtr[AW]) &&
                          (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

endmodule

// File: rtl/m_usr_frame_pack.sv
// ---------------------------------------------------------------------------
// m_usr_frame_pack
// Buffers 512-bit user words in a FWFT FIFO and emits fixed-length frames on a
// 128-bit stream: one header beat, then FRAME_WORDS x 4 payload beats, least
// significant 128 bits of each word first. Words arriving while the FIFO is
// full are dropped, counted and flagged; the next header reports them.
//
// Stream handshake: a beat transfers on a rising edge where CpSl_TxVld_o and
// CpSl_TxRdy_i are both high. Payload beats, once valid, hold data and last
// until they transfer. The header beat samples the frame/drop counters and
// overflow flag live, so it always reports every drop seen up to its own
// transfer (a drop in the transfer cycle itself goes to the next header).
//
// Ports:
//   CpSl_Clk_i      in   user clock
//   CpSl_Rst_iN     in   asynchronous active-low reset
//   CpSl_UsrDvld_i  in   input word valid (no backpressure upstream)
//   CpSv_UsrData_i  in   512-bit input word
//   CpSl_TxVld_o    out  output beat valid
//   CpSl_TxRdy_i    in   downstream ready
//   CpSv_TxData_o   out  128-bit output beat
//   CpSl_TxLast_o   out  last beat of frame
//   CpSl_Ovf_o      out  sticky overflow, cleared when a header transfers
// ---------------------------------------------------------------------------
module m_usr_frame_pack
    import m_frame_pkg::*;
#(
    parameter int FRAME_WORDS = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic         CpSl_Clk_i,
    input  logic         CpSl_Rst_iN,
    input  logic         CpSl_UsrDvld_i,
    input  logic [511:0] CpSv_UsrData_i,
    output logic         CpSl_TxVld_o,
    input  logic         CpSl_TxRdy_i,
    output logic [127:0] CpSv_TxData_o,
    output logic         CpSl_TxLast_o,
    output logic         CpSl_Ovf_o
);

    localparam logic [15:0] FRAME_LEN = 16'(FRAME_WORDS);
    localparam logic [15:0] LAST_WORD = 16'(FRAME_WORDS - 1);

    logic [WORD_W-1:0] fifoHead;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPush;
    logic              fifoPop;

    frameCtl_t         ctlQ;
    frameCtl_t         ctlD;
    logic              hdrHs;
    logic              dropEvt;
    logic              isLastBeat;

    logic [31:0]       frameCntQ;
    logic [31:0]       frameCntD;
    logic [15:0]       dropCntQ;
    logic [15:0]       dropCntD;
    logic              ovfQ;
    logic              ovfD;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifoPush = CpSl_UsrDvld_i & (~fifoFull | fifoPop);
    assign dropEvt  = CpSl_UsrDvld_i & fifoFull & ~fifoPop;

    m_usr_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .CpSl_Clk_i   (CpSl_Clk_i),
        .CpSl_Rst_iN  (CpSl_Rst_iN),
        .CpSl_Push_i  (fifoPush),
        .CpSv_Din_i   (CpSv_UsrData_i),
        .CpSl_Pop_i   (fifoPop),
        .CpSv_Head_o  (fifoHead),
        .CpSl_Full_o  (fifoFull),
        .CpSl_Empty_o (fifoEmpty)
    );

    // FSM state register
    always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
        if (!CpSl_Rst_iN) begin
            ctlQ.state   <= ST_IDLE;
            ctlQ.beatIdx <= '0;
            ctlQ.wordIdx <= '0;
        end else begin
            ctlQ <= ctlD;
        end
    end

    // FSM next state and stream outputs
    always_comb begin
        ctlD          = ctlQ;
        CpSl_TxVld_o  = 1'b0;
        CpSv_TxData_o = '0;
        CpSl_TxLast_o = 1'b0;
        fifoPop       = 1'b0;
        hdrHs         = 1'b0;
        isLastBeat    = (ctlQ.beatIdx == 2'd3) && (ctlQ.wordIdx == LAST_WORD);

        case (ctlQ.state)
            ST_IDLE: begin
                if (!fifoEmpty) ctlD.state = ST_HDR;
            end

            ST_HDR: begin
                CpSl_TxVld_o  = 1'b1;
                CpSv_TxData_o = buildHeader(frameCntQ, FRAME_LEN, dropCntQ, ovfQ);
                if (CpSl_TxRdy_i) begin
                    hdrHs        = 1'b1;
                    ctlD.state   = ST_PAY;
                    ctlD.beatIdx = '0;
                    ctlD.wordIdx = '0;
                end
            end

            ST_PAY: begin
                // An empty FIFO only stalls the frame; it never ends early.
                CpSl_TxVld_o = ~fifoEmpty;
                if (!fifoEmpty) begin
                    CpSv_TxData_o = fifoHead[{ctlQ.beatIdx, 7'd0} +: BEAT_W];
                    CpSl_TxLast_o = isLastBeat;
                    if (CpSl_TxRdy_i) begin
                        if (ctlQ.beatIdx == 2'd3) begin
                            fifoPop      = 1'b1;
                            ctlD.beatIdx = '0;
                            if (isLastBeat) begin
                                ctlD.state   = ST_IDLE;
                                ctlD.wordIdx = '0;
                            end else begin
                                ctlD.wordIdx = ctlQ.wordIdx + 16'd1;
                            end
                        end else begin
                            ctlD.beatIdx = ctlQ.beatIdx + 2'd1;
                        end
                    end
                end
            end

            default: begin
                ctlD.state = ST_IDLE;
            end
        endcase
    end

    // Counters: a drop in the header-transfer cycle wins over the clear.
    always_comb begin
        frameCntD = hdrHs ? (frameCntQ + 32'd1) : frameCntQ;
        dropCntD  = dropCntQ;
        if (dropEvt) begin
            if (hdrHs)                       dropCntD = 16'd1;
            else if (dropCntQ != 16'hFFFF)   dropCntD = dropCntQ + 16'd1;
        end else if (hdrHs) begin
            dropCntD = '0;
        end
        ovfD = dropEvt | (ovfQ & ~hdrHs);
    end

    always_ff @(posedge CpSl_Clk_i or negedge CpSl_Rst_iN) begin
        if (!CpSl_Rst_iN) begin
            frameCntQ <= '0;
            dropCntQ  <= '0;
            ovfQ      <= 1'b0;
        end else begin
            frameCntQ <= frameCntD;
            dropCntQ  <= dropCntD;
            ovfQ      <= ovfD;
        end
    end

    assign CpSl_Ovf_o = ovfQ;

endmodule

// File: tb/tb_m_usr_frame_pack.sv
// ---------------------------------------------------------------------------
// tb_m_usr_frame_pack
// Directed bench for m_usr_frame_pack with FRAME_WORDS=2, FIFO_DEPTH=8.
// Input word k carries 128-bit lanes k*0x1000 + {3,2,1,0}, so each payload
// beat identifies its word and lane. Inputs change on the falling edge and
// outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_m_usr_frame_pack;

    localparam int FW = 2;
    localparam int FD = 8;

    logic         clk    = 1'b0;
    logic         rstN   = 1'b0;
    logic         dvld   = 1'b0;
    logic [511:0] udata  = '0;
    logic         rdy    = 1'b0;
    logic         txVld;
    logic [127:0] txData;
    logic         txLast;
    logic         ovf;

    int           nPass  = 0;
    int           nTotal = 0;
    int           collectCycles;
    logic [127:0] gotData[$];
    logic         gotLast[$];

    always #5 clk = ~clk;

    m_usr_frame_pack #(
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .CpSl_Clk_i     (clk),
        .CpSl_Rst_iN    (rstN),
        .CpSl_UsrDvld_i (dvld),
        .CpSv_UsrData_i (udata),
        .CpSl_TxVld_o   (txVld),
        .CpSl_TxRdy_i   (rdy),
        .CpSv_TxData_o  (txData),
        .CpSl_TxLast_o  (txLast),
        .CpSl_Ovf_o     (ovf)
    );

    function automatic logic [511:0] mkWord(input int k);
        logic [127:0] b;
        b = 128'(k) * 128'h1000;
        return {b + 128'd3, b + 128'd2, b + 128'd1, b};
    endfunction

    function automatic logic [127:0] expPay(input int k, input int lane);
        return 128'(k) * 128'h1000 + 128'(lane);
    endfunction

    function automatic logic [127:0] expHdr(input logic [31:0] fc, input logic [15:0] dc,
                                            input logic ov);
        return {32'hEB90146F, fc, 16'd2, dc, 31'd0, ov};
    endfunction

    // ---------------- clock / reset ----------------
    task automatic doReset();
        rstN = 1'b0;
        dvld = 1'b0;
        rdy  = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic pushWords(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            dvld  = 1'b1;
            udata = mkWord(first + i);
            @(negedge clk);
        end
        dvld = 1'b0;
    endtask

    // Collects n transferred beats; toggle=1 alternates ready 1/0 and checks
    // that a stalled beat is held unchanged.
    task automatic collectBeats(input int n, input bit toggle);
        logic         stalled;
        logic [127:0] hData;
        logic         hLast;
        int           cyc;
        gotData.delete();
        gotLast.delete();
        stalled = 1'b0;
        hData   = '0;
        hLast   = 1'b0;
        cyc     = 0;
        while (gotData.size() < n && cyc < 400) begin
            rdy = (toggle && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
            if (stalled) begin
                nTotal++;
                if (txVld !== 1'b1 || txData !== hData || txLast !== hLast)
                    $display("FAIL stall_hold: got vld=%b data=%h last=%b, need vld=1 data=%h last=%b",
                             txVld, txData, txLast, hData, hLast);
                else nPass++;
            end
            if (txVld === 1'b1 && rdy) begin
                gotData.push_back(txData);
                gotLast.push_back(txLast);
            end
            stalled = (txVld === 1'b1) && !rdy;
            hData   = txData;
            hLast   = txLast;
            @(negedge clk);
            cyc++;
        end
        rdy = 1'b0;
        collectCycles = cyc;
        nTotal++;
        if (gotData.size() != n)
            $display("FAIL collect_count: got %0d beats, need %0d", gotData.size(), n);
        else nPass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        doReset();
        nTotal++; if (txVld !== 1'b0) $display("FAIL reset_vld: got %b need 0", txVld); else nPass++;
        nTotal++; if (txData !== 128'd0) $display("FAIL reset_data: got %h need 0", txData); else nPass++;
        nTotal++; if (txLast !== 1'b0) $display("FAIL reset_last: got %b need 0", txLast); else nPass++;
        nTotal++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b need 0", ovf); else nPass++;
    endtask

    task automatic test_single_frame();
        logic [127:0] e;
        doReset();
        rdy   = 1'b1;
        dvld  = 1'b1;
        udata = mkWord(1);
        @(negedge clk);
        nTotal++; if (txVld !== 1'b0) $display("FAIL sf_latency_early: vld=%b need 0", txVld); else nPass++;
        udata = mkWord(2);
        @(negedge clk);
        dvld = 1'b0;
        nTotal++; if (txVld !== 1'b1) $display("FAIL sf_latency_hdr: vld=%b need 1", txVld); else nPass++;
        collectBeats(9, 1'b0);
        nTotal++;
        if (collectCycles != 9) $display("FAIL sf_throughput: took %0d cycles need 9", collectCycles);
        else nPass++;
        for (int j = 0; j < 9; j++) begin
            e = (j == 0) ? expHdr(32'd0, 16'd0, 1'b0) : expPay(1 + (j - 1) / 4, (j - 1) % 4);
            nTotal++;
            if (gotData[j] !== e) $display("FAIL sf_data[%0d]: got %h need %h", j, gotData[j], e);
            else nPass++;
            nTotal++;
            if (gotLast[j] !== (j == 8)) $display("FAIL sf_last[%0d]: got %b need %b", j, gotLast[j], j == 8);
            else nPass++;
        end
        nTotal++; if (txVld !== 1'b0) $display("FAIL sf_idle_after: vld=%b need 0", txVld); else nPass++;
    endtask

    task automatic test_backpressure();
        logic [127:0] e;
        doReset();
        pushWords(3, 2);
        collectBeats(9, 1'b1);
        for (int j = 0; j < 9; j++) begin
            e = (j == 0) ? expHdr(32'd0, 16'd0, 1'b0) : expPay(3 + (j - 1) / 4, (j - 1) % 4);
            nTotal++;
            if (gotData[j] !== e) $display("FAIL bp_data[%0d]: got %h need %h", j, gotData[j], e);
            else nPass++;
            nTotal++;
            if (gotLast[j] !== (j == 8)) $display("FAIL bp_last[%0d]: got %b need %b", j, gotLast[j], j == 8);
            else nPass++;
        end
    endtask

    task automatic test_overflow();
        logic [127:0] e;
        int f;
        int b;
        doReset();
        pushWords(1, 8);
        nTotal++; if (ovf !== 1'b0) $display("FAIL ovf_before_drop: got %b need 0", ovf); else nPass++;
        pushWords(9, 1);
        nTotal++; if (ovf !== 1'b1) $display("FAIL ovf_first_drop: got %b need 1", ovf); else nPass++;
        pushWords(10, 2);
        collectBeats(36, 1'b0);
        for (int j = 0; j < 36; j++) begin
            f = j / 9;
            b = j % 9;
            if (b == 0) e = expHdr(32'(f), (f == 0) ? 16'd3 : 16'd0, f == 0);
            else        e = expPay(2 * f + 1 + (b - 1) / 4, (b - 1) % 4);
            nTotal++;
            if (gotData[j] !== e) $display("FAIL ov_data[%0d]: got %h need %h", j, gotData[j], e);
            else nPass++;
            nTotal++;
            if (gotLast[j] !== (b == 8)) $display("FAIL ov_last[%0d]: got %b need %b", j, gotLast[j], b == 8);
            else nPass++;
        end
        nTotal++; if (ovf !== 1'b0) $display("FAIL ovf_cleared: got %b need 0", ovf); else nPass++;
    endtask

    task automatic test_drop_on_header();
        logic [127:0] e;
        doReset();
        pushWords(1, 8);
        // FIFO full, header pending: release ready and push a ninth word together.
        rdy   = 1'b1;
        dvld  = 1'b1;
        udata = mkWord(9);
        nTotal++;
        if (txVld !== 1'b1 || txData !== expHdr(32'd0, 16'd0, 1'b0))
            $display("FAIL dh_hdr0: vld=%b data=%h need vld=1 data=%h", txVld, txData,
                     expHdr(32'd0, 16'd0, 1'b0));
        else nPass++;
        @(negedge clk);
        dvld = 1'b0;
        nTotal++; if (ovf !== 1'b1) $display("FAIL dh_ovf_set: got %b need 1", ovf); else nPass++;
        collectBeats(18, 1'b0);
        for (int j = 0; j < 8; j++) begin
            e = expPay(1 + j / 4, j % 4);
            nTotal++;
            if (gotData[j] !== e) $display("FAIL dh_pay[%0d]: got %h need %h", j, gotData[j], e);
            else nPass++;
        end
        e = expHdr(32'd1, 16'd1, 1'b1);
        nTotal++; if (gotData[8] !== e) $display("FAIL dh_hdr1: got %h need %h", gotData[8], e); else nPass++;
        e = expHdr(32'd2, 16'd0, 1'b0);
        nTotal++; if (gotData[17] !== e) $display("FAIL dh_hdr2: got %h need %h", gotData[17], e); else nPass++;
    endtask

    task automatic test_frame_wrap();
        logic [127:0] e;
        doReset();
        force dut.frameCntQ = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.frameCntQ;
        pushWords(1, 4);
        collectBeats(18, 1'b0);
        e = expHdr(32'hFFFFFFFF, 16'd0, 1'b0);
        nTotal++; if (gotData[0] !== e) $display("FAIL wrap_hdr_max: got %h need %h", gotData[0], e); else nPass++;
        e = expHdr(32'd0, 16'd0, 1'b0);
        nTotal++; if (gotData[9] !== e) $display("FAIL wrap_hdr_zero: got %h need %h", gotData[9], e); else nPass++;
        nTotal++; if (gotLast[17] !== 1'b1) $display("FAIL wrap_last: got %b need 1", gotLast[17]); else nPass++;
    endtask

    task automatic test_async_reset();
        logic [127:0] e;
        doReset();
        pushWords(1, 9);
        collectBeats(3, 1'b0);
        #2 rstN = 1'b0;
        #1;
        nTotal++; if (txVld !== 1'b0) $display("FAIL ar_vld: got %b need 0", txVld); else nPass++;
        nTotal++; if (txData !== 128'd0) $display("FAIL ar_data: got %h need 0", txData); else nPass++;
        nTotal++; if (txLast !== 1'b0) $display("FAIL ar_last: got %b need 0", txLast); else nPass++;
        nTotal++; if (ovf !== 1'b0) $display("FAIL ar_ovf: got %b need 0", ovf); else nPass++;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        pushWords(5, 2);
        collectBeats(9, 1'b0);
        for (int j = 0; j < 9; j++) begin
            e = (j == 0) ? expHdr(32'd0, 16'd0, 1'b0) : expPay(5 + (j - 1) / 4, (j - 1) % 4);
            nTotal++;
            if (gotData[j] !== e) $display("FAIL ar_data[%0d]: got %h need %h", j, gotData[j], e);
            else nPass++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_drop_on_header();
        test_frame_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
